debounce_pulse: RTL

- Conditions a raw asynchronous pushbutton/switch input into a clean debounced level plus single-cycle press/release strobes.
- Sits directly upstream of the free-running enable counter. `rise` drives the counter's `en`, so the counter advances exactly once per physical press.
- Single clock domain, asynchronous active-high reset.

---
 rtl/debounce_pulse.sv | 123 ++++++++++++
 1 files changed

// File: rtl/debounce_pulse.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-count debounce, registered press/release strobes.
// Optional auto-repeat of the press strobe while held: define DEBOUNCE_AUTOREPEAT_EN.
module debounce_pulse #(
    parameter int cnt_w         = 16,
    parameter int stable        = 1000,
    parameter int repeat_delay  = 500,
    parameter int repeat_period = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    typedef enum logic [1:0] {RELEASED = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {RELEASED = 2'd0, HELD = 2'd1} state_t;
`endif

    if (stable < 2 || stable >= (1 << cnt_w) || repeat_delay < 2 || repeat_period < 2)
    begin : g_bad_param
        $error("debounce_pulse: illegal stable/repeat parameter for cnt_w");
    end

    localparam logic [cnt_w-1:0] STABLE_M1 = cnt_w'(stable - 1);

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [cnt_w-1:0] dc_q, dc_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch, qualified;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [cnt_w-1:0] DELAY_M1  = cnt_w'(repeat_delay - 1);
    localparam logic [cnt_w-1:0] PERIOD_M1 = cnt_w'(repeat_period - 1);
    logic [cnt_w-1:0] rc_q, rc_d;
`endif

    assign mismatch  = (sync2_q != level_q);
    // Qualifying edge: this is the stable-th consecutive cycle of disagreement.
    assign qualified = mismatch && (dc_q == STABLE_M1);

    always_comb begin
        state_d = state_q;
        dc_d    = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rc_d    = '0;
`endif
        if (mismatch && !qualified) begin
            dc_d = dc_q + cnt_w'(1);
        end
        case (state_q)
            RELEASED: begin
                if (qualified) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end
            end
            default: begin
                if (qualified) begin
                    state_d = RELEASED;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                // Release wins over a repeat strobe due in the same cycle.
                else if (state_q == HELD && rc_q == DELAY_M1) begin
                    state_d = REPEAT;
                    rise_d  = 1'b1;
                end else if (state_q == REPEAT && rc_q == PERIOD_M1) begin
                    rise_d  = 1'b1;
                end else begin
                    rc_d = rc_q + cnt_w'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= RELEASED;
            dc_q    <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            state_q <= state_d;
            dc_q    <= dc_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end
`endif

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule
